// File: rtl/iterm_integrator_p_pkg.sv
// Shared types and default sizing for the integral-term block and its siblings.
package iterm_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DECAY} iterm_state_t;

   localparam int ERR_W_DEF    = 10;
   localparam int ACC_W_DEF    = 15;
   localparam int OUT_W_DEF    = 9;
   localparam int DECAY_SH_DEF = 3;

endpackage

// File: rtl/iterm_integrator_p_if.sv
// Sample/control inputs and I-term outputs between error stage, integrator and PID summer.
interface iterm_integrator_p_if #(
   parameter int ERR_W = iterm_pkg::ERR_W_DEF,
   parameter int OUT_W = iterm_pkg::OUT_W_DEF
);
   logic                    err_vld;
   logic                    moving;
   logic                    hold;
   logic                    clr;
   logic signed [ERR_W-1:0] err_sat;
   logic signed [OUT_W-1:0] I_term;
   logic                    I_vld;
   logic                    sat;
   logic                    decaying;

   modport master (
      output err_vld, moving, hold, clr, err_sat,
      input  I_term, I_vld, sat, decaying
   );

   modport slave (
      input  err_vld, moving, hold, clr, err_sat,
      output I_term, I_vld, sat, decaying
   );
endinterface

// File: rtl/iterm_integrator_p_sat_add.sv
// Signed saturating adder: clamps to the representable range and flags when it did.
module sat_add #(
   parameter int W = 15
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                clamped
);
   logic signed [W:0] full;

   assign full = {a[W-1], a} + {b[W-1], b};

   // Overflow shows as disagreement between the guard bit and the result sign.
   always_comb begin
      sum     = full[W-1:0];
      clamped = 1'b0;
      if (full[W] != full[W-1]) begin
         clamped = 1'b1;
         sum     = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
endmodule

// File: rtl/iterm_integrator_p.sv
// Integral term: saturating accumulate while moving, geometric decay to zero when stopped.
module iterm_integrator_p
   import iterm_pkg::*;
#(
   parameter int ERR_W    = ERR_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter int DECAY_SH = DECAY_SH_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   iterm_integrator_p_if.slave io
);

   if (ACC_W <= ERR_W) begin : g_bad_acc_w
      $error("iterm_integrator_p: ACC_W must be greater than ERR_W");
   end
   if (OUT_W > ACC_W) begin : g_bad_out_w
      $error("iterm_integrator_p: OUT_W must not exceed ACC_W");
   end

   iterm_state_t            state, state_n;
   logic signed [ACC_W-1:0] acc, acc_n;
   logic                    sat_q, sat_n;
   logic                    ivld_q, ivld_n;

   logic signed [ACC_W-1:0] err_ext;
   logic signed [ACC_W-1:0] add_sum;
   logic                    add_clamp;
   logic signed [ACC_W-1:0] dec_d;
   logic                    dec_snap;

   assign err_ext = {{(ACC_W-ERR_W){io.err_sat[ERR_W-1]}}, io.err_sat};

   sat_add #(.W(ACC_W)) u_sat_add (
      .a       (acc),
      .b       (err_ext),
      .sum     (add_sum),
      .clamped (add_clamp)
   );

   // Floor shift leaves -1 for small negatives, so snap on 0 or -1 to guarantee termination.
   assign dec_d    = acc >>> DECAY_SH;
   assign dec_snap = (dec_d == '0) || (dec_d == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         sat_q  <= 1'b0;
         ivld_q <= 1'b0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         sat_q  <= sat_n;
         ivld_q <= ivld_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      sat_n   = sat_q;
      ivld_n  = 1'b0;
      if (io.clr) begin
         state_n = IDLE;
         acc_n   = '0;
         sat_n   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               acc_n = '0;
               if (io.moving) state_n = RUN;
            end
            RUN: begin
               if (!io.moving) begin
                  state_n = DECAY;
                  sat_n   = 1'b0;
               end else if (io.err_vld && !io.hold) begin
                  acc_n  = add_sum;
                  sat_n  = add_clamp;
                  ivld_n = 1'b1;
               end
            end
            DECAY: begin
               // Resuming motion keeps the partially decayed value as the new starting point.
               if (io.moving) begin
                  state_n = RUN;
               end else if (dec_snap) begin
                  acc_n   = '0;
                  state_n = IDLE;
               end else begin
                  acc_n = acc - dec_d;
               end
            end
            default: begin
               state_n = IDLE;
               acc_n   = '0;
               sat_n   = 1'b0;
            end
         endcase
      end
   end

   assign io.I_term   = acc[ACC_W-1 -: OUT_W];
   assign io.I_vld    = ivld_q;
   assign io.sat      = sat_q;
   assign io.decaying = (state == DECAY);

endmodule

// File: tb/tb_iterm_integrator_p.sv
// Directed bench for iterm_integrator_p with a queue-based scoreboard on I_vld.
module tb_iterm_integrator_p;
   import iterm_pkg::*;

   localparam int ERR_W = 10;
   localparam int ACC_W = 15;
   localparam int OUT_W = 9;
   localparam int DSH   = 3;
   localparam int AMAX  = 16383;
   localparam int AMIN  = -16384;

   logic clk = 1'b0;
   logic rst_n;

   iterm_integrator_p_if #(.ERR_W(ERR_W), .OUT_W(OUT_W)) io ();

   iterm_integrator_p #(.ERR_W(ERR_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .DECAY_SH(DSH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   iterm;
      logic sat;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   m_acc  = 0;
   logic m_sat  = 1'b0;
   bit   in_run = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int exp_iterm(input int a);
      logic signed [ACC_W-1:0] t;
      t = a[ACC_W-1:0];
      return int'($signed(t[ACC_W-1 -: OUT_W]));
   endfunction

   // Monitor: every I_vld pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && io.I_vld) begin
         if (sbq.size() == 0) begin
            chk("spurious_ivld", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_iterm", int'(io.I_term), e.iterm);
            chk("sb_sat", int'(io.sat), int'(e.sat));
         end
      end
   end

   task automatic pulse(input int e);
      int s;
      @(negedge clk);
      io.err_vld = 1'b1;
      io.err_sat = e[ERR_W-1:0];
      if (in_run && io.moving && !io.hold) begin
         s = m_acc + e;
         m_sat = 1'b0;
         if (s > AMAX) begin s = AMAX; m_sat = 1'b1; end
         if (s < AMIN) begin s = AMIN; m_sat = 1'b1; end
         m_acc = s;
         sbq.push_back('{exp_iterm(m_acc), m_sat});
      end
      @(negedge clk);
      io.err_vld = 1'b0;
   endtask

   task automatic drained(input string name);
      @(negedge clk);
      @(negedge clk);
      chk(name, sbq.size(), 0);
   endtask

   task automatic do_clr();
      @(negedge clk);
      io.clr = 1'b1;
      @(negedge clk);
      io.clr = 1'b0;
      m_acc = 0; m_sat = 1'b0; in_run = 1'b0;
      chk("clr_iterm", int'(io.I_term), 0);
      @(negedge clk);
      in_run = 1'b1;
   endtask

   // Called with moving just dropped; follows the decay to IDLE one edge at a time.
   task automatic decay_run(input string name);
      int  d;
      bit  m_dec;
      m_dec  = 1'b1;
      in_run = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         chk({name, "_decaying"}, int'(io.decaying), int'(m_dec));
         chk({name, "_iterm"}, int'(io.I_term), exp_iterm(m_acc));
         if (!m_dec) return;
         d = m_acc >>> DSH;
         if (d == 0 || d == -1) begin m_acc = 0; m_dec = 1'b0; end
         else m_acc = m_acc - d;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      io.err_vld = 1'b0; io.moving = 1'b0; io.hold = 1'b0; io.clr = 1'b0; io.err_sat = '0;
      repeat (3) @(negedge clk);
      chk("rst_iterm", int'(io.I_term), 0);
      chk("rst_ivld", int'(io.I_vld), 0);
      chk("rst_sat", int'(io.sat), 0);
      chk("rst_decaying", int'(io.decaying), 0);
      rst_n = 1'b1;
      @(negedge clk);
      io.moving = 1'b1;
      @(negedge clk);
      in_run = 1'b1;

      // 1: four +64 samples -> 256, I_term 4
      repeat (4) pulse(64);
      drained("t1_drain");
      chk("t1_iterm", int'(io.I_term), 4);
      chk("t1_sat", int'(io.sat), 0);

      // 2: positive clamp, step back off, negative clamp
      do_clr();
      repeat (33) pulse(511);
      drained("t2_drain_pos");
      chk("t2_pos_iterm", int'(io.I_term), 255);
      chk("t2_pos_sat", int'(io.sat), 1);
      pulse(-1);
      drained("t2_drain_back");
      chk("t2_back_sat", int'(io.sat), 0);
      do_clr();
      repeat (33) pulse(-512);
      drained("t2_drain_neg");
      chk("t2_neg_iterm", int'(io.I_term), -256);
      chk("t2_neg_sat", int'(io.sat), 1);

      // 3: hold suppresses accumulation and I_vld
      do_clr();
      repeat (4) pulse(64);
      io.hold = 1'b1;
      repeat (5) pulse(100);
      io.hold = 1'b0;
      chk("t3_hold_iterm", int'(io.I_term), 4);
      pulse(8);
      drained("t3_drain");
      chk("t3_iterm", int'(io.I_term), 4);

      // 4: positive and negative decay to zero
      do_clr();
      repeat (4) pulse(64);
      drained("t4_drain_pos");
      @(negedge clk);
      io.moving = 1'b0;
      decay_run("t4_pos");
      io.moving = 1'b1;
      @(negedge clk);
      in_run = 1'b1;
      repeat (4) pulse(-64);
      drained("t4_drain_neg");
      @(negedge clk);
      io.moving = 1'b0;
      decay_run("t4_neg");
      io.moving = 1'b1;
      @(negedge clk);
      in_run = 1'b1;

      // 5: resume mid-decay at 196, then drop moving with a coincident sample
      do_clr();
      repeat (4) pulse(64);
      drained("t5_drain");
      @(negedge clk);
      io.moving = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("t5_dec_iterm", int'(io.I_term), 3);
      chk("t5_dec_flag", int'(io.decaying), 1);
      io.moving = 1'b1;
      @(negedge clk);
      chk("t5_resume_flag", int'(io.decaying), 0);
      chk("t5_resume_iterm", int'(io.I_term), 3);
      m_acc = 196; in_run = 1'b1;
      pulse(4);
      drained("t5_drain2");
      chk("t5_after_iterm", int'(io.I_term), 3);
      io.moving = 1'b0;
      io.err_vld = 1'b1;
      io.err_sat = 10'sd100;
      @(negedge clk);
      io.err_vld = 1'b0;
      chk("t5_drop_decaying", int'(io.decaying), 1);
      chk("t5_drop_iterm", int'(io.I_term), 3);
      io.moving = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // 6: clr beats a coincident sample; async reset mid-decay
      do_clr();
      repeat (5) pulse(100);
      drained("t6_drain");
      chk("t6_pre_iterm", int'(io.I_term), 7);
      @(negedge clk);
      io.clr = 1'b1;
      io.err_vld = 1'b1;
      io.err_sat = 10'sd50;
      @(negedge clk);
      io.clr = 1'b0;
      io.err_vld = 1'b0;
      chk("t6_clr_iterm", int'(io.I_term), 0);
      chk("t6_clr_decaying", int'(io.decaying), 0);
      chk("t6_clr_ivld", int'(io.I_vld), 0);
      m_acc = 0; m_sat = 1'b0;
      @(negedge clk);
      in_run = 1'b1;
      repeat (4) pulse(64);
      drained("t6_drain2");
      io.moving = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_pre_rst_decaying", int'(io.decaying), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_iterm", int'(io.I_term), 0);
      chk("t6_rst_ivld", int'(io.I_vld), 0);
      chk("t6_rst_sat", int'(io.sat), 0);
      chk("t6_rst_decaying", int'(io.decaying), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
